// File: rtl/photon_cnt_fifo.sv
// Circular FIFO buffering g-domain photon-count words for host readout, with sticky overflow tracking.
// Define PHOTON_CNT_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle-latency reads.
module photon_cnt_fifo #(
   parameter int COUNTSIZE = 32,
   parameter int ADDRW     = 6,
   parameter int OVFW      = 16
) (
   input  logic                 g_clk,
   input  logic                 g_rst,
   input  logic                 g_valid,
   input  logic [COUNTSIZE-1:0] g_sync2_diff_count,
   input  logic                 g_flush,
   input  logic                 g_rd_en,
   output logic [COUNTSIZE-1:0] g_rd_data,
   output logic                 g_rd_valid,
   output logic                 g_empty,
   output logic                 g_full,
   output logic [ADDRW:0]       g_level,
   output logic                 g_ovf,
   input  logic                 g_ovf_clr,
   output logic [OVFW-1:0]      g_ovf_cnt
);
   localparam int DEPTH = 2**ADDRW;
   localparam logic [ADDRW:0] FULL_LVL = {1'b1, {ADDRW{1'b0}}};

   logic [COUNTSIZE-1:0] mem [DEPTH];
   logic [ADDRW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [COUNTSIZE-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 ovf_q, ovf_d;
   logic [OVFW-1:0]      ovf_cnt_q, ovf_cnt_d;
   logic                 rd_acc, wr_acc, drop;
   logic [ADDRW:0]       lvl;

   assign lvl     = wr_ptr_q - rd_ptr_q;
   assign g_level = lvl;
   assign g_full  = (lvl == FULL_LVL);
   assign g_empty = (lvl == '0);

   // Flush overrides both ports; a write blocked by flush is neither stored nor dropped.
   assign rd_acc = g_rd_en & ~g_empty & ~g_flush;
   assign wr_acc = g_valid & (~g_full | rd_acc) & ~g_flush;
   assign drop   = g_valid & g_full & ~rd_acc & ~g_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (g_flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

`ifdef PHOTON_CNT_FIFO_FWFT_EN
   // Output register always mirrors the head; bypass covers a write landing in an empty FIFO.
   logic [ADDRW:0] lvl_d;
   assign lvl_d = wr_ptr_d - rd_ptr_d;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = (lvl_d != '0);
      if (rd_valid_d) begin
         if (wr_acc && (wr_ptr_q[ADDRW-1:0] == rd_ptr_d[ADDRW-1:0]))
            rd_data_d = g_sync2_diff_count;
         else
            rd_data_d = mem[rd_ptr_d[ADDRW-1:0]];
      end
   end
`else
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = mem[rd_ptr_q[ADDRW-1:0]];
   end
`endif

   always_comb begin
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      if (g_ovf_clr) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = drop ? OVFW'(1) : '0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (!(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge g_clk) begin
      if (wr_acc) mem[wr_ptr_q[ADDRW-1:0]] <= g_sync2_diff_count;
   end

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign g_rd_data  = rd_data_q;
   assign g_rd_valid = rd_valid_q;
   assign g_ovf      = ovf_q;
   assign g_ovf_cnt  = ovf_cnt_q;
endmodule

// File: doc/photon_cnt_fifo.md
Name: photon_cnt_fifo

Overview:
- g-domain buffer directly downstream of cdc_g2ram. Captures each g_valid pulse and its g_sync2_diff_count word into a circular FIFO.
- Presents the words to the host readout interface through a read-enable handshake.
- Reports fill level. Counts samples dropped on overflow so the host can detect gaps in the photon-count stream.

Parameters:
- COUNTSIZE, 32, width of one count word (matches cdc_g2ram output).
- ADDRW, 6, FIFO address width; depth = 2**ADDRW entries (64).
- OVFW, 16, width of the overflow drop counter.

Ports:
- g_clk  input  1  g-domain clock; all logic on rising edge.
- g_rst  input  1  asynchronous, active-high reset.
- g_valid  input  1  one-cycle strobe from cdc_g2ram: new count word available.
- g_sync2_diff_count  input  COUNTSIZE  count word, sampled when g_valid=1.
- g_flush  input  1  synchronous clear of FIFO contents.
- g_rd_en  input  1  host read request / pop.
- g_rd_data  output  COUNTSIZE  read data.
- g_rd_valid  output  1  g_rd_data is valid this cycle.
- g_empty  output  1  no unread words.
- g_full  output  1  2**ADDRW words stored.
- g_level  output  ADDRW+1  number of stored, unpopped words.
- g_ovf  output  1  sticky: at least one sample dropped.
- g_ovf_clr  input  1  clears g_ovf and g_ovf_cnt.
- g_ovf_cnt  output  OVFW  dropped-sample count, saturating.

Behaviour:
- Reset (g_rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, g_level=0, g_empty=1, g_full=0.
  - g_rd_valid=0, g_rd_data=0, g_ovf=0, g_ovf_cnt=0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all words, including the word in flight to g_rd_data.
- Pointers are ADDRW+1 bits, binary, wrapping naturally.
  - g_level = wr_ptr - rd_ptr, taken modulo 2**(ADDRW+1).
  - g_full = (g_level == 2**ADDRW); g_empty = (g_level == 0). Both are registered/derived from registered pointers only.
- Write:
  - A word is accepted at the edge where g_valid=1 and either (not g_full) or a read is accepted in the same cycle.
  - On accept: mem[wr_ptr[ADDRW-1:0]] <= data; wr_ptr increments.
- Drop:
  - Occurs at the edge where g_valid=1, g_full=1 and no read is accepted that cycle.
  - Word is discarded; g_ovf <= 1; g_ovf_cnt increments, saturating at 2**OVFW-1.
  - Simultaneous drop and g_ovf_clr: the clear wins for the flag, and g_ovf_cnt loads 1.
- Read (standard mode):
  - A read is accepted when g_rd_en=1 and g_empty=0.
  - g_rd_data <= mem[rd_ptr] and g_rd_valid=1 on the next cycle; rd_ptr increments.
  - g_rd_en while g_empty=1 is ignored: g_rd_valid=0 and g_rd_data holds its last value.
  - Latency is exactly 1 cycle.
- Simultaneous accepted read and write: g_level unchanged.
  - On an empty FIFO only the write takes effect; a read is never accepted while g_empty=1.
- Flush (g_flush=1):
  - Next edge: rd_ptr <= wr_ptr, g_rd_valid <= 0.
  - A write in the same cycle is discarded and is not counted as a drop.
  - g_ovf and g_ovf_cnt are unaffected.
- g_rd_data is COUNTSIZE wide and unmodified; no arithmetic is applied to counts.

Optional Feature:
- Macro: PHOTON_CNT_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - The head word is prefetched into the g_rd_data output register.
  - g_rd_valid=1 whenever at least one word is stored; g_rd_data shows the head with no request.
  - g_rd_en with g_rd_valid=1 pops the head; the next word, if any, appears the following cycle with g_rd_valid still 1.
  - A write into an empty FIFO at edge N gives g_rd_valid=1 from the cycle after edge N.
  - g_level includes the presented word.
  - g_rd_en with g_rd_valid=0 is ignored.
- Undefined: standard 1-cycle-latency read as described under Behaviour.

Test Plan:
- Write 3 words 0x10, 0x20, 0x30 (g_valid pulses 9 cycles apart), then g_rd_en for 3 cycles:
  - g_level goes 1, 2, 3.
  - Reads return 0x10, 0x20, 0x30 in order, each with g_rd_valid 1 cycle after its g_rd_en (standard mode).
  - End state: g_empty=1, g_level=0.
- Write 64 words (values 0..63), then 2 more (values 100, 101):
  - g_full=1, g_ovf=1, g_ovf_cnt=2.
  - Reading 64 words returns 0..63; 100 and 101 never appear.
- At full, assert g_valid and g_rd_en in the same cycle:
  - Head word is read; new word is stored; g_level stays 64; g_ovf_cnt unchanged.
- Fill 5 words, read 1, pulse g_flush:
  - Next cycle g_empty=1, g_level=0, g_rd_valid=0.
  - A new write of 0x55 followed by a read returns 0x55.
- Assert g_rst asynchronously mid-read with 10 words stored and g_ovf=1:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Pointer wrap check after reset: 200 sequential write/read pairs return data in order with no corruption.
- With PHOTON_CNT_FIFO_FWFT_EN defined, write 0xABCD into the empty FIFO:
  - g_rd_valid=1 and g_rd_data=0xABCD one cycle later with no g_rd_en.
  - A pop then sets g_rd_valid=0 and g_empty=1.
